// File: rtl/ifu_prefetch_buf_pkg.sv
// Shared constants for the instruction prefetch buffer.
// Holds the instruction/address bus widths, the NOP encoding presented when
// the buffer is empty, the default reset fetch address, and the fetch stride.
package ifu_prefetch_buf_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;

  localparam logic [INST_W-1:0]      INST_NOP         = 32'h0000_0001;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] FETCH_STRIDE     = 32'd4;

endpackage

// File: rtl/ifu_pf_fifo.sv
// Generic synchronous FIFO used by the prefetch buffer.
// Read data is the registered head entry (no write-to-read bypass).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, wdata    write request and data (accepted when not full, or when
//                  a pop frees the slot in the same cycle)
//   pop            read request (ignored when empty)
//   clear          empties the FIFO; wins over push and pop
//   rdata          head entry
//   full, empty    occupancy flags
//   count          number of stored entries
module ifu_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // live, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer between the RIB fetch port and if_id.
// Issues sequential word fetches ahead of decode, buffers each response with
// its address, and hands one instruction per cycle to decode (valid/ready).
// A redirect (flush) discards buffered entries and any in-flight response.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   flush_i, flush_addr_i         redirect request and word-aligned target
//   fetch_req_o, fetch_addr_o     fetch request / address to the RIB
//   fetch_gnt_i                   request accepted this cycle
//   fetch_rvalid_i, fetch_rdata_i response, one cycle after an accepted request
//   inst_valid_o, inst_o,
//   inst_addr_o                   buffer head (NOP / 0 when empty)
//   inst_ready_i                  decode consumes the head
module ifu_prefetch_buf
  import ifu_prefetch_buf_pkg::*;
#(
  parameter int                     DEPTH    = 4,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] flush_addr_i,
  output logic                   fetch_req_o,
  output logic [INST_ADDR_W-1:0] fetch_addr_o,
  input  logic                   fetch_gnt_i,
  input  logic                   fetch_rvalid_i,
  input  logic [INST_W-1:0]      fetch_rdata_i,
  output logic                   inst_valid_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] inst_addr_o,
  input  logic                   inst_ready_i
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INST_ADDR_W + INST_W;

  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_ADDR_W-1:0] pend_addr_q;
  logic                   pend_q;
  logic                   drop_q;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [ENTRY_W-1:0]     fifo_rdata;
  logic [CNT_W:0]         occupancy;
  logic                   issue;

  // Buffered entries plus the one outstanding response must fit, so a
  // response never finds the FIFO full. The full term is implied by the
  // occupancy limit and only guards against a malformed DEPTH.
  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};
  assign fetch_req_o = rst && !flush_i && !fifo_full
                       && (occupancy < (CNT_W+1)'(DEPTH));
  assign fetch_addr_o = pc_q;
  assign issue        = fetch_req_o && fetch_gnt_i;

  // An rvalid with nothing outstanding, or one marked for discard, is dropped.
  assign fifo_push = fetch_rvalid_i && pend_q && !drop_q;
  assign fifo_pop  = inst_valid_o && inst_ready_i;

  ifu_pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({pend_addr_q, fetch_rdata_i}),
    .pop   (fifo_pop),
    .clear (flush_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? INST_NOP : fifo_rdata[INST_W-1:0];
  assign inst_addr_o  = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:INST_W];

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of pc_q/pend_q regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else if (flush_i) begin
      // A response still owed to the old stream arrives after the redirect
      // and must not be buffered.
      pc_q   <= flush_addr_i;
      pend_q <= 1'b0;
      drop_q <= pend_q;
    end else begin
      drop_q <= 1'b0;
      if (issue) begin
        pc_q        <= pc_q + FETCH_STRIDE;
        pend_q      <= 1'b1;
        pend_addr_q <= pc_q;
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Self-checking bench for ifu_prefetch_buf: directed scenarios plus a
// randomized run, all checked against a queue-based model of the buffer.
module tb_ifu_prefetch_buf;
  import ifu_prefetch_buf_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i;
  logic        fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  ifu_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .flush_addr_i   (flush_addr_i),
    .fetch_req_o    (fetch_req_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_gnt_i    (fetch_gnt_i),
    .fetch_rvalid_i (fetch_rvalid_i),
    .fetch_rdata_i  (fetch_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_ready_i   (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the buffer as a queue of {addr, data}, the next fetch
  // address, and at most one response still owed to the current stream.
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_fly;
  logic [31:0] m_fly_addr;

  logic        exp_req;
  logic [31:0] exp_addr;
  logic        exp_valid;
  logic [31:0] exp_inst;
  logic [31:0] exp_iaddr;

  // Memory responder state: what the RIB accepted last cycle.
  bit          acc_prev;
  logic [31:0] acc_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = RPC;
    m_fly    = 1'b0;
    acc_prev = 1'b0;
    acc_addr = 32'h0;
  endtask

  task automatic do_reset();
    flush_i = 1'b0; flush_addr_i = 32'h0; fetch_gnt_i = 1'b0;
    inst_ready_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = 32'h0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called in the low clock phase: applies inputs, then derives the
  // expected outputs for this cycle from the model.
  task automatic drive(input logic f, input logic [31:0] fa, input logic g,
                       input logic r, input logic spur);
    flush_i        = f;
    flush_addr_i   = fa;
    fetch_gnt_i    = g;
    inst_ready_i   = r;
    fetch_rvalid_i = acc_prev || spur;
    fetch_rdata_i  = mem_word(acc_addr);
    #1;
    exp_req  = !f && ((m_q.size() + (m_fly ? 1 : 0)) < DEPTH);
    exp_addr = m_pc;
    exp_valid = (m_q.size() != 0);
    if (exp_valid) begin
      exp_inst  = m_q[0].data;
      exp_iaddr = m_q[0].addr;
    end else begin
      exp_inst  = INST_NOP;
      exp_iaddr = 32'h0;
    end
  endtask

  // Commits the current cycle to the model and the responder, then moves to
  // the next low phase.
  task automatic advance();
    bit          acc_now;
    logic [31:0] addr_now;
    acc_now  = (fetch_req_o === 1'b1) && (fetch_gnt_i === 1'b1);
    addr_now = fetch_addr_o;
    if (flush_i) begin
      m_q.delete();
      m_pc  = flush_addr_i;
      m_fly = 1'b0;
    end else begin
      if (m_q.size() != 0 && inst_ready_i) void'(m_q.pop_front());
      if (fetch_rvalid_i && m_fly) m_q.push_back('{addr: m_fly_addr, data: mem_word(m_fly_addr)});
      if (exp_req && fetch_gnt_i) begin
        m_fly      = 1'b1;
        m_fly_addr = m_pc;
        m_pc       = m_pc + 32'd4;
      end else begin
        m_fly = 1'b0;
      end
    end
    @(posedge clk);
    acc_prev = acc_now;
    acc_addr = addr_now;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (fetch_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", fetch_req_o); end
    n_cmp++; if (fetch_addr_o !== RPC) begin n_err++; $display("FAIL rst_fetch_addr: got %h expected %h", fetch_addr_o, RPC); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
    n_cmp++; if (inst_o !== 32'h1) begin n_err++; $display("FAIL rst_inst: got %h expected 00000001", inst_o); end
    n_cmp++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_inst_addr: got %h expected 0", inst_addr_o); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fetch_req_o !== 1'b1) begin n_err++; $display("FAIL rel_req: got %b expected 1", fetch_req_o); end
    n_cmp++; if (fetch_addr_o !== RPC) begin n_err++; $display("FAIL rel_addr: got %h expected %h", fetch_addr_o, RPC); end
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      a = RPC + 32'(4 * k);
      n_cmp++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== a) begin n_err++; $display("FAIL stream_req c%0d: got %b/%h expected 1/%h", k, fetch_req_o, fetch_addr_o, a); end
      if (k >= 2) begin
        a = RPC + 32'(4 * (k - 2));
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== a || inst_o !== mem_word(a)) begin n_err++; $display("FAIL stream_out c%0d: got %b/%h/%h expected 1/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, a, mem_word(a)); end
      end else begin
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_early_valid c%0d: got %b expected 0", k, inst_valid_o); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int          acc;
    bit          seen;
    logic [31:0] first;
    acc = 0; seen = 1'b0; first = 32'h0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      if (fetch_req_o === 1'b1) acc++;
      advance();
    end
    n_cmp++; if (acc !== DEPTH) begin n_err++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH); end
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (j == 0) begin
        n_cmp++; if (fetch_req_o !== 1'b0) begin n_err++; $display("FAIL bp_full_req: got %b expected 0", fetch_req_o); end
      end
      n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * j) || inst_o !== mem_word(32'(4 * j))) begin n_err++; $display("FAIL bp_drain %0d: got %b/%h/%h expected 1/%h", j, inst_valid_o, inst_addr_o, inst_o, 32'(4 * j)); end
      if (!seen && fetch_req_o === 1'b1) begin seen = 1'b1; first = fetch_addr_o; end
      advance();
    end
    n_cmp++; if (!seen || first !== 32'h10) begin n_err++; $display("FAIL bp_resume: got seen=%b addr=%h expected seen=1 addr=00000010", seen, first); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      advance();
    end
    // Request to 0x10 was accepted last cycle; its response arrives now.
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fetch_req_o !== 1'b0) begin n_err++; $display("FAIL flush_cycle_req: got %b expected 0", fetch_req_o); end
    advance();
    // A late stale 0x10 response is offered and must be ignored.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h200) begin n_err++; $display("FAIL flush_t1_req: got %b/%h expected 1/00000200", fetch_req_o, fetch_addr_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_t1_valid: got %b expected 0", inst_valid_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_t2_valid: got %b/%h expected 0", inst_valid_o, inst_addr_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h200 || inst_o !== 32'h213) begin n_err++; $display("FAIL flush_t3_out: got %b/%h/%h expected 1/00000200/00000213", inst_valid_o, inst_addr_o, inst_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_addr_o !== 32'h204) begin n_err++; $display("FAIL flush_t4_addr: got %h expected 00000204", inst_addr_o); end
    advance();
  endtask

  task automatic test_gnt_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      advance();
    end
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hC) begin n_err++; $display("FAIL stall_hold %0d: got %b/%h expected 1/0000000c", s, fetch_req_o, fetch_addr_o); end
      if (s == 2) begin
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_no_push: got %b/%h expected 0", inst_valid_o, inst_addr_o); end
      end
      advance();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fetch_addr_o !== 32'hC) begin n_err++; $display("FAIL stall_resume_addr: got %h expected 0000000c", fetch_addr_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hC) begin n_err++; $display("FAIL stall_resume_out: got %b/%h expected 1/0000000c", inst_valid_o, inst_addr_o); end
    advance();
  endtask

  task automatic test_flush_at_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      advance();
    end
    // Three buffered plus one response arriving: flush, pop and push coincide.
    drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin n_err++; $display("FAIL ff_pre_head: got %b/%h expected 1/00000000", inst_valid_o, inst_addr_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h1 || inst_addr_o !== 32'h0) begin n_err++; $display("FAIL ff_empty: got %b/%h/%h expected 0/00000001/00000000", inst_valid_o, inst_o, inst_addr_o); end
    n_cmp++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h300) begin n_err++; $display("FAIL ff_target: got %b/%h expected 1/00000300", fetch_req_o, fetch_addr_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL ff_stale: got %b/%h expected 0", inst_valid_o, inst_addr_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h300) begin n_err++; $display("FAIL ff_first: got %b/%h expected 1/00000300", inst_valid_o, inst_addr_o); end
    advance();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      advance();
    end
    drive(1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || fetch_req_o !== 1'b0) begin n_err++; $display("FAIL b2b_full: got valid=%b req=%b expected 1/0", inst_valid_o, fetch_req_o); end
    advance();
    drive(1'b1, 32'h600, 1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fetch_addr_o !== 32'h600 || inst_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_target: got %h/%b expected 00000600/0", fetch_addr_o, inst_valid_o); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h600) begin n_err++; $display("FAIL b2b_first: got %b/%h expected 1/00000600", inst_valid_o, inst_addr_o); end
    advance();
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    logic [31:0] a;
    base = 32'hFFFF_FFF8;
    do_reset();
    drive(1'b1, base, 1'b1, 1'b1, 1'b0);
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      a = base + 32'(4 * k);
      n_cmp++; if (fetch_addr_o !== a) begin n_err++; $display("FAIL wrap_fetch %0d: got %h expected %h", k, fetch_addr_o, a); end
      if (k >= 2) begin
        a = base + 32'(4 * (k - 2));
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== a) begin n_err++; $display("FAIL wrap_out %0d: got %b/%h expected 1/%h", k, inst_valid_o, inst_addr_o, a); end
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin n_err++; $display("FAIL mr_pre: got %b/%h expected 1/00000000", inst_valid_o, inst_addr_o); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h1 || inst_addr_o !== 32'h0) begin n_err++; $display("FAIL mr_async_out: got %b/%h/%h expected 0/00000001/00000000", inst_valid_o, inst_o, inst_addr_o); end
    n_cmp++; if (fetch_req_o !== 1'b0 || fetch_addr_o !== RPC) begin n_err++; $display("FAIL mr_async_fetch: got %b/%h expected 0/%h", fetch_req_o, fetch_addr_o, RPC); end
    model_reset();
    fetch_rvalid_i = 1'b0; fetch_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== RPC) begin n_err++; $display("FAIL mr_restart: got %b/%h expected 1/%h", fetch_req_o, fetch_addr_o, RPC); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== RPC) begin n_err++; $display("FAIL mr_first: got %b/%h expected 1/%h", inst_valid_o, inst_addr_o, RPC); end
    advance();
  endtask

  task automatic test_random();
    logic        f;
    logic [31:0] fa;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      f  = ($urandom_range(0, 99) < 3);
      fa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C)) : ($urandom & 32'hFFFF_FFFC);
      drive(f, fa, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
      n_cmp++; if (fetch_req_o !== exp_req) begin n_err++; $display("FAIL rnd_req c%0d: got %b expected %b", c, fetch_req_o, exp_req); end
      n_cmp++; if (fetch_addr_o !== exp_addr) begin n_err++; $display("FAIL rnd_fetch_addr c%0d: got %h expected %h", c, fetch_addr_o, exp_addr); end
      n_cmp++; if (inst_valid_o !== exp_valid) begin n_err++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, inst_valid_o, exp_valid); end
      n_cmp++; if (inst_o !== exp_inst) begin n_err++; $display("FAIL rnd_inst c%0d: got %h expected %h", c, inst_o, exp_inst); end
      n_cmp++; if (inst_addr_o !== exp_iaddr) begin n_err++; $display("FAIL rnd_inst_addr c%0d: got %h expected %h", c, inst_addr_o, exp_iaddr); end
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_gnt_stall();
    test_flush_at_full();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch_buf.md
# ifu_prefetch_buf

Instruction prefetch buffer between the RIB instruction-fetch port and `if_id`. It issues sequential word fetches ahead of decode and buffers each returned instruction with its address in a small FIFO. It presents one instruction per cycle to the decode side under a valid/ready handshake. On a control-flow redirect it discards all buffered and in-flight data.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0: first fetch address after reset.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  redirect request (jump / interrupt entry).
- `flush_addr_i`  in  32  redirect target; word-aligned.
- `fetch_req_o`  out  1  fetch request to the RIB.
- `fetch_addr_o`  out  32  fetch address.
- `fetch_gnt_i`  in  1  request accepted this cycle (driven as `~rib_hold_flag_i`).
- `fetch_rvalid_i`  in  1  response valid, exactly 1 cycle after an accepted request.
- `fetch_rdata_i`  in  32  fetched instruction.
- `inst_valid_o`  out  1  FIFO head valid.
- `inst_o`  out  32  head instruction; `INST_NOP` (32'h00000001) when empty.
- `inst_addr_o`  out  32  head address; 0 when empty.
- `inst_ready_i`  in  1  decode consumes the head (low when `ctrl` hold ≥ `Hold_Pc`).

## Operation
- State: FIFO of {addr, inst}, `rd_ptr`/`wr_ptr` with log2(DEPTH)+1 bits (wrap bit gives full/empty), `pc_q` (next fetch address), `pend_q` (one request outstanding), `pend_addr_q`, `drop_q` (discard next response).
- Issue: `fetch_req_o = !flush_i && (count + pend_q) < DEPTH`; `fetch_addr_o = pc_q`. On `fetch_req_o && fetch_gnt_i`: `pc_q += 4` (32-bit wrap, 0xFFFFFFFC→0), `pend_q ← 1`, `pend_addr_q ← pc_q`. Otherwise `pend_q ← 0`.
- Response: `fetch_rvalid_i && !drop_q` pushes {`pend_addr_q`, `fetch_rdata_i`}. A response with `drop_q = 1` is ignored. Space is guaranteed by the issue rule. An `rvalid` without a pending request is ignored.
- Pop: `inst_valid_o && inst_ready_i` advances `rd_ptr`.
- Push and pop in the same cycle: count is unchanged. This holds at full and at empty+1.
- Flush priority: flush overrides push, pop and issue in the same cycle.
  - Next cycle: pointers equal (empty), `pc_q ← flush_addr_i`, `drop_q ← pend_q`, `pend_q ← 0`.
  - No request is issued in the flush cycle.
  - Back-to-back flushes: the last target wins.
- `drop_q` clears after one cycle.
- Reset: asynchronous. Mid-operation reset discards all state.

## Timing
- Reset values:
  - `fetch_req_o` = 0 while `rst` is low; then 1 from the first cycle after release.
  - `fetch_addr_o` = `RESET_PC`.
  - `inst_valid_o` = 0, `inst_o` = 32'h00000001, `inst_addr_o` = 0.
  - Internal: ptrs 0, `pend_q` = 0, `drop_q` = 0.
- Outputs `inst_*` are registered FIFO reads; there is no request→decode bypass.
- Latency: request accepted in cycle t → `fetch_rvalid_i` in t+1 → `inst_valid_o` in t+2.
- Flush in cycle t:
  - First request to the target in t+1.
  - First valid instruction at the target in t+3.
  - `inst_valid_o` = 0 in t+1 and t+2.
- Throughput: 1 instruction/cycle sustained while `fetch_gnt_i` = 1 and `inst_ready_i` = 1.

## Structure
- `INST_NOP`, `RESET_PC` default, `InstBus`/`InstAddrBus` widths come from the shared `defines.v`. No new typedefs.
- One sub-module: `ifu_pf_fifo`, a generic synchronous FIFO.
  - Parameters: `DEPTH`, `WIDTH` = 64.
  - Ports: push, pop, clear, full, empty, count.
- The top level holds the issue/pending/drop logic (~60 lines). The FIFO is ~80 lines.

## Test plan
- Reset release, `RESET_PC` = 0, gnt = 1, rdata = addr|0x13, ready = 1 → requests 0,4,8,… on consecutive cycles; `inst_valid_o` from cycle 2; `inst_addr_o` 0,4,8 with matching data.
- ready = 0 with DEPTH = 4 → exactly 4 entries buffered; `fetch_req_o` drops after 4 accepted requests. Raise ready → entries pop in order 0,4,8,C; fetching resumes at 0x10.
- `flush_i` to 0x200 while a request to 0x10 is outstanding → the 0x10 response is discarded; next valid `inst_addr_o` = 0x200, 3 cycles after the flush.
- `fetch_gnt_i` = 0 for 3 cycles → `fetch_addr_o` held constant; no push; `pc_q` is not advanced.
- Simultaneous flush + pop + push at full → empty the next cycle; `pc_q` = target; no stale entry emitted.
- `rst` asserted mid-stream with 2 entries buffered → outputs reach their reset values immediately (asynchronously); after release, fetch restarts at `RESET_PC`.
